gate_response_checker: RTL and testbench
========================================

// Module: gate_response_checker
// PURPOSE
//  - Checks the response of a combinational gate under test in hardware. It is the consuming end of our
//    exhaustive-stimulus flow: the stimulus side applies input vectors; this block scores the observed output.
//  - Each {vector, observed output} pair is compared with a 2**N_IN-bit truth table latched at start.
//  - Reports pass/fail, a saturating mismatch count and the first failing vector.
// PARAMETERS
//  - N_IN     4   number of gate inputs; truth table is 2**N_IN bits
//  - NUM_VEC  16  vectors per run; run ends after this many accepted vectors (1..2**16-1)
//  - CNT_W    8   width of fail_cnt (saturating)
// PORTS
//  - clk             in   1          rising-edge clock
//  - rst_n           in   1          asynchronous active-low reset
//  - start           in   1          1-cycle pulse: latch truth_tbl, clear results, enter RUN
//  - truth_tbl       in   2**N_IN    expected output; bit i = expected y for vector value i
//  - vec_valid       in   1          vec_in/y_obs valid this cycle
//  - vec_in          in   N_IN       applied input vector {a,b,c,d,...}, MSB = a
//  - y_obs           in   1          observed gate output for vec_in
//  - busy            out  1          high in RUN
//  - done            out  1          high in DONE; held until next start
//  - pass            out  1          done && no mismatch (&& full coverage, see CONFIGURATION)
//  - fail_cnt        out  CNT_W      mismatches this run, saturates at all-ones
//  - first_fail_vld  out  1          a mismatch has been captured this run
//  - first_fail_vec  out  N_IN       vec_in of first mismatch
//  - vec_cnt         out  16         vectors accepted this run
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; all outputs 0, including first_fail_vec and tbl_q. Release is synchronised internally.
//  - States:
//    - IDLE --start--> RUN
//    - RUN --(NUM_VEC-th accepted vector)--> DONE
//    - DONE --start--> RUN
//    - RUN --start--> RUN: restart; clears all results, re-latches table.
//  - On start: tbl_q<=truth_tbl; fail_cnt, vec_cnt, first_fail_*, done, pass <= 0; busy<=1 next cycle.
//  - A vector is accepted only when vec_valid && state==RUN && !start.
//    - A vector in the start cycle is dropped.
//    - vec_valid in IDLE/DONE is ignored; no counter changes.
//  - Compare: mism = y_obs ^ tbl_q[vec_in]. Results are registered, 1-cycle latency from the accepted vector.
//  - On accepted mismatch:
//    - fail_cnt+1, saturating at 2**CNT_W-1.
//    - If !first_fail_vld, capture first_fail_vec=vec_in and set first_fail_vld=1. Later mismatches never overwrite it.
//  - vec_cnt increments per accepted vector.
//    - The NUM_VEC-th vector is scored, then state=DONE in the same update: done=1, busy=0, pass evaluated with that vector included.
//  - One vector per cycle, no backpressure. Back-to-back valid is supported at full rate.
//  - Repeated vectors are allowed and each is scored independently.
//  - Mid-run reset aborts immediately to reset values. Partial results are lost.
// CONFIGURATION
//  - CHK_COVERAGE_EN defined:
//    - Adds output cov_map [2**N_IN-1:0]: bit i set when vector i is accepted in this run; cleared on start/reset.
//    - pass additionally requires &cov_map; a run with repeats that misses a vector fails.
//  - CHK_COVERAGE_EN undefined: cov_map port absent; pass = done && fail_cnt==0.
// TESTING
//  - XNOR ok: start with truth_tbl=16'h9669, apply vectors 0..15 with y=~^vec, 1/cycle
//    -> done=1, pass=1, fail_cnt=0, vec_cnt=16, first_fail_vld=0.
//  - OR with faults: truth_tbl=16'hFFFE, vectors 0..15, y_obs forced 0 at vectors 5 and 12
//    -> fail_cnt=2, first_fail_vec=4'd5, pass=0.
//  - Saturation: CNT_W=2, NUM_VEC=16, all y_obs inverted -> fail_cnt=3, first_fail_vec=0, pass=0.
//  - Handshake edges:
//    - vec_valid in IDLE -> vec_cnt stays 0.
//    - vec_valid in the start cycle -> dropped.
//    - start at vec_cnt=7 -> counters cleared, run completes after 16 further vectors.
//  - Reset mid-run: rst_n low after 9 vectors (one mismatch) -> all outputs 0 asynchronously, state IDLE, next start runs clean.
//  - CHK_COVERAGE_EN: 16 vectors all correct but vector 9 replaced by a repeat of 8
//    -> fail_cnt=0, cov_map=16'hFDFF, pass=0.
//    - Without the macro the same run -> pass=1.

Source files
------------

// File: rtl/gate_response_checker_if.sv
// Vector/response bus from the stimulus side into the response checker.
// One {vec_in, y_obs} pair per cycle while vec_valid is high; no backpressure.
interface gate_response_checker_if #(
    parameter int N_IN = 4
);
    logic            vec_valid;
    logic [N_IN-1:0] vec_in;
    logic            y_obs;

    modport master (output vec_valid, vec_in, y_obs);
    modport slave  (input  vec_valid, vec_in, y_obs);
endinterface

// File: rtl/gate_response_checker.sv
// Scores observed gate outputs against a truth table latched at start.
// Optional CHK_COVERAGE_EN adds cov_map and makes pass require full coverage.
module gate_response_checker #(
    parameter int N_IN    = 4,
    parameter int NUM_VEC = 16,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [(2**N_IN)-1:0]  truth_tbl,
    gate_response_checker_if.slave vif,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_W-1:0]      fail_cnt,
    output logic                  first_fail_vld,
    output logic [N_IN-1:0]       first_fail_vec,
    output logic [15:0]           vec_cnt
`ifdef CHK_COVERAGE_EN
    ,
    output logic [(2**N_IN)-1:0]  cov_map
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(NUM_VEC - 1);

    state_t               state_q;
    state_t               state_d;
    logic [1:0]           rst_sync;
    logic                 rst_i_n;
    logic [(2**N_IN)-1:0] tbl_q;
    logic                 accept;
    logic                 mism;
    logic                 last_vec;

    // Assert asynchronously, release two clocks after rst_n rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_i_n  = rst_sync[1];
    assign accept   = vif.vec_valid && (state_q == RUN) && !start;
    assign mism     = vif.y_obs ^ tbl_q[vif.vec_in];
    assign last_vec = accept && (vec_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN: begin
                if (start)         state_d = RUN;
                else if (last_vec) state_d = DONE;
            end
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            tbl_q          <= '0;
            fail_cnt       <= '0;
            vec_cnt        <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
`ifdef CHK_COVERAGE_EN
            cov_map        <= '0;
`endif
        end else if (start) begin
            tbl_q          <= truth_tbl;
            fail_cnt       <= '0;
            vec_cnt        <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
`ifdef CHK_COVERAGE_EN
            cov_map        <= '0;
`endif
        end else if (accept) begin
            vec_cnt <= vec_cnt + 16'd1;
            if (mism) begin
                if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                if (!first_fail_vld) begin
                    first_fail_vld <= 1'b1;
                    first_fail_vec <= vif.vec_in;
                end
            end
`ifdef CHK_COVERAGE_EN
            cov_map[vif.vec_in] <= 1'b1;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

`ifdef CHK_COVERAGE_EN
    assign pass = done && (fail_cnt == '0) && (&cov_map);
`else
    assign pass = done && (fail_cnt == '0);
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker; a CNT_W=2 copy shares the
// stimulus to exercise counter saturation.
module tb_gate_response_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] truth_tbl;

    logic        busy, done, pass, first_fail_vld;
    logic [7:0]  fail_cnt;
    logic [3:0]  first_fail_vec;
    logic [15:0] vec_cnt;

    logic        busy2, done2, pass2, first_fail_vld2;
    logic [1:0]  fail_cnt2;
    logic [3:0]  first_fail_vec2;
    logic [15:0] vec_cnt2;
`ifdef CHK_COVERAGE_EN
    logic [15:0] cov_map, cov_map2;
`endif

    int vecs = 0;
    int errs = 0;

    gate_response_checker_if #(.N_IN(4)) vif ();

    gate_response_checker #(.N_IN(4), .NUM_VEC(16), .CNT_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .truth_tbl      (truth_tbl),
        .vif            (vif.slave),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_cnt       (fail_cnt),
        .first_fail_vld (first_fail_vld),
        .first_fail_vec (first_fail_vec),
        .vec_cnt        (vec_cnt)
`ifdef CHK_COVERAGE_EN
        ,
        .cov_map        (cov_map)
`endif
    );

    gate_response_checker #(.N_IN(4), .NUM_VEC(16), .CNT_W(2)) dut2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .truth_tbl      (truth_tbl),
        .vif            (vif.slave),
        .busy           (busy2),
        .done           (done2),
        .pass           (pass2),
        .fail_cnt       (fail_cnt2),
        .first_fail_vld (first_fail_vld2),
        .first_fail_vec (first_fail_vec2),
        .vec_cnt        (vec_cnt2)
`ifdef CHK_COVERAGE_EN
        ,
        .cov_map        (cov_map2)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] tbl);
        truth_tbl = tbl;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic apply(input logic [3:0] v, input logic y);
        vif.vec_valid = 1'b1;
        vif.vec_in    = v;
        vif.y_obs     = y;
        step();
        vif.vec_valid = 1'b0;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        vecs++;
        if ({busy, done, pass, first_fail_vld} !== 4'b0000) begin
            errs++;
            $display("FAIL reset_flags got %b want 0000",
                     {busy, done, pass, first_fail_vld});
        end
        vecs++;
        if ({fail_cnt, first_fail_vec, vec_cnt} !== 28'h0) begin
            errs++;
            $display("FAIL reset_counts got %h want 0",
                     {fail_cnt, first_fail_vec, vec_cnt});
        end
    endtask

    task automatic test_idle_valid();
        for (int i = 0; i < 3; i++) apply(4'(i), 1'b1);
        vecs++;
        if (vec_cnt !== 16'd0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL idle_valid got cnt=%0d busy=%b want 0 0",
                     vec_cnt, busy);
        end
    endtask

    task automatic test_xnor();
        do_start(16'h9669);
        vecs++;
        if (busy !== 1'b1 || vec_cnt !== 16'd0) begin
            errs++;
            $display("FAIL xnor_busy got busy=%b cnt=%0d want 1 0",
                     busy, vec_cnt);
        end
        apply(4'd0, 1'b1);
        vecs++;
        if (vec_cnt !== 16'd1) begin
            errs++;
            $display("FAIL xnor_latency got %0d want 1", vec_cnt);
        end
        for (int i = 1; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            apply(v, ~^v);
        end
        vecs++;
        if ({done, pass, busy, first_fail_vld} !== 4'b1100) begin
            errs++;
            $display("FAIL xnor_flags got %b want 1100",
                     {done, pass, busy, first_fail_vld});
        end
        vecs++;
        if (fail_cnt !== 8'd0 || vec_cnt !== 16'd16) begin
            errs++;
            $display("FAIL xnor_counts got f=%0d c=%0d want 0 16",
                     fail_cnt, vec_cnt);
        end
        apply(4'd3, 1'b1);
        vecs++;
        if (vec_cnt !== 16'd16 || fail_cnt !== 8'd0 || done !== 1'b1) begin
            errs++;
            $display("FAIL done_ignore got c=%0d f=%0d d=%b want 16 0 1",
                     vec_cnt, fail_cnt, done);
        end
    endtask

    task automatic test_or_faults();
        do_start(16'hFFFE);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            apply(v, (i == 5 || i == 12) ? 1'b0 : (|v));
        end
        vecs++;
        if (fail_cnt !== 8'd2) begin
            errs++;
            $display("FAIL or_fail_cnt got %0d want 2", fail_cnt);
        end
        vecs++;
        if (first_fail_vld !== 1'b1 || first_fail_vec !== 4'd5) begin
            errs++;
            $display("FAIL or_first got v=%b vec=%0d want 1 5",
                     first_fail_vld, first_fail_vec);
        end
        vecs++;
        if (done !== 1'b1 || pass !== 1'b0) begin
            errs++;
            $display("FAIL or_pass got d=%b p=%b want 1 0", done, pass);
        end
    endtask

    task automatic test_saturation();
        do_start(16'h9669);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            apply(v, ^v);
        end
        vecs++;
        if (fail_cnt2 !== 2'd3) begin
            errs++;
            $display("FAIL sat_cnt2 got %0d want 3", fail_cnt2);
        end
        vecs++;
        if (fail_cnt !== 8'd16) begin
            errs++;
            $display("FAIL sat_cnt8 got %0d want 16", fail_cnt);
        end
        vecs++;
        if (first_fail_vec2 !== 4'd0 || pass2 !== 1'b0 || done2 !== 1'b1) begin
            errs++;
            $display("FAIL sat_result got vec=%0d p=%b d=%b want 0 0 1",
                     first_fail_vec2, pass2, done2);
        end
    endtask

    task automatic test_start_drop();
        vif.vec_valid = 1'b1;
        vif.vec_in    = 4'd0;
        vif.y_obs     = 1'b0;
        do_start(16'h9669);
        vif.vec_valid = 1'b0;
        vecs++;
        if (vec_cnt !== 16'd0 || fail_cnt !== 8'd0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL start_drop got c=%0d f=%0d b=%b want 0 0 1",
                     vec_cnt, fail_cnt, busy);
        end
    endtask

    task automatic test_restart();
        for (int i = 0; i < 7; i++) begin
            logic [3:0] v;
            v = 4'(i);
            apply(v, (i == 2) ? (^v) : (~^v));
        end
        vecs++;
        if (vec_cnt !== 16'd7 || fail_cnt !== 8'd1) begin
            errs++;
            $display("FAIL pre_restart got c=%0d f=%0d want 7 1",
                     vec_cnt, fail_cnt);
        end
        do_start(16'h9669);
        vecs++;
        if ({vec_cnt, fail_cnt} !== 24'h0 || first_fail_vld !== 1'b0 ||
            busy !== 1'b1) begin
            errs++;
            $display("FAIL restart_clear got c=%0d f=%0d v=%b b=%b want 0 0 0 1",
                     vec_cnt, fail_cnt, first_fail_vld, busy);
        end
        for (int i = 0; i < 15; i++) begin
            logic [3:0] v;
            v = 4'(i);
            apply(v, ~^v);
        end
        vecs++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL restart_15 got d=%b b=%b want 0 1", done, busy);
        end
        apply(4'd15, 1'b1);
        vecs++;
        if (done !== 1'b1 || pass !== 1'b1 || vec_cnt !== 16'd16) begin
            errs++;
            $display("FAIL restart_done got d=%b p=%b c=%0d want 1 1 16",
                     done, pass, vec_cnt);
        end
    endtask

    task automatic test_reset_midrun();
        do_start(16'h9669);
        for (int i = 0; i < 9; i++) begin
            logic [3:0] v;
            v = 4'(i);
            apply(v, (i == 3) ? (^v) : (~^v));
        end
        vecs++;
        if (vec_cnt !== 16'd9 || fail_cnt !== 8'd1 || first_fail_vec !== 4'd3) begin
            errs++;
            $display("FAIL pre_reset got c=%0d f=%0d v=%0d want 9 1 3",
                     vec_cnt, fail_cnt, first_fail_vec);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({busy, done, pass, first_fail_vld} !== 4'b0000 ||
            {fail_cnt, first_fail_vec, vec_cnt} !== 28'h0) begin
            errs++;
            $display("FAIL async_reset got %b %h want 0",
                     {busy, done, pass, first_fail_vld},
                     {fail_cnt, first_fail_vec, vec_cnt});
        end
        step();
        release_reset();
        do_start(16'h9669);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            apply(v, ~^v);
        end
        vecs++;
        if (pass !== 1'b1 || fail_cnt !== 8'd0 || vec_cnt !== 16'd16) begin
            errs++;
            $display("FAIL post_reset got p=%b f=%0d c=%0d want 1 0 16",
                     pass, fail_cnt, vec_cnt);
        end
    endtask

    task automatic test_coverage();
        do_start(16'h9669);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = (i == 9) ? 4'd8 : 4'(i);
            apply(v, ~^v);
        end
        vecs++;
        if (fail_cnt !== 8'd0 || done !== 1'b1) begin
            errs++;
            $display("FAIL cov_fail_cnt got f=%0d d=%b want 0 1",
                     fail_cnt, done);
        end
`ifdef CHK_COVERAGE_EN
        vecs++;
        if (cov_map !== 16'hFDFF) begin
            errs++;
            $display("FAIL cov_map got %h want fdff", cov_map);
        end
        vecs++;
        if (pass !== 1'b0) begin
            errs++;
            $display("FAIL cov_pass got %b want 0", pass);
        end
`else
        vecs++;
        if (pass !== 1'b1) begin
            errs++;
            $display("FAIL cov_pass got %b want 1", pass);
        end
`endif
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        truth_tbl     = '0;
        vif.vec_valid = 1'b0;
        vif.vec_in    = '0;
        vif.y_obs     = 1'b0;
        repeat (2) step();
        test_reset();
        release_reset();
        test_idle_valid();
        test_xnor();
        test_or_faults();
        test_saturation();
        test_start_drop();
        test_restart();
        test_reset_midrun();
        test_coverage();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
